// File: rtl/pulse_sync_pkg.sv
// Shared types and default constants for the pulse synchronizer scheduler.
package pulse_sync_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_CNT_W   = 3;
   localparam int DEF_GAP     = 2;
   localparam int DEF_TMO     = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP_WAIT
   } state_e;

endpackage

// File: rtl/pulse_sync_sched_rr_arb.sv
// Round-robin picker: first requester with pending events at or after ptr_i, wrapping to 0.
module rr_arb
   import pulse_sync_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         pend_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   input  logic                       en_i,
   output logic [$clog2(NUM_REQ)-1:0] gnt_o,
   output logic                       valid_o
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [2*NUM_REQ-1:0] pendDbl;
   logic [NUM_REQ-1:0]   pendRot;
   logic [ID_W:0]        gntSum;
   logic                 found;

   // Rotate the pending vector so bit 0 is the pointer position, then take the first set bit
   // and map its offset back to an absolute requester index.
   always_comb begin
      pendDbl = {pend_i, pend_i} >> ptr_i;
      pendRot = pendDbl[NUM_REQ-1:0];
      found   = 1'b0;
      gntSum  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && pendRot[k]) begin
            found  = 1'b1;
            gntSum = {1'b0, ptr_i} + (ID_W+1)'(k);
         end
      end
      if (gntSum >= (ID_W+1)'(NUM_REQ)) begin
         gntSum = gntSum - (ID_W+1)'(NUM_REQ);
      end
      gnt_o   = gntSum[ID_W-1:0];
      valid_o = en_i && found;
   end

endmodule

// File: rtl/pulse_sync_sched.sv
// Schedules per-requester event pulses onto a single pulse-synchronizer handshake.
module pulse_sync_sched
   import pulse_sync_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int GAP     = DEF_GAP,
   parameter int TMO     = DEF_TMO
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       busy,
   output logic                       sync_pulse,
   output logic [$clog2(NUM_REQ)-1:0] sync_id,
   output logic [NUM_REQ-1:0]         drop,
   output logic                       tmo_err,
   output logic                       idle
);

   localparam int              ID_W    = $clog2(NUM_REQ);
   localparam int              TMO_W   = $clog2(TMO + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e              state_q;
   logic [CNT_W-1:0]    pendCnt_q [NUM_REQ];
   logic [CNT_W-1:0]    pendCnt_d [NUM_REQ];
   logic [NUM_REQ-1:0]  drop_q;
   logic [NUM_REQ-1:0]  drop_d;
   logic [NUM_REQ-1:0]  pendNz;
   logic [ID_W-1:0]     rrPtr_q;
   logic [ID_W-1:0]     syncId_q;
   logic                syncPulse_q;
   logic                tmoErr_q;
   logic [TMO_W-1:0]    tmoCnt_q;
   logic [3:0]          gapCnt_q;
   logic [ID_W-1:0]     gntIdx;
   logic                gntValid;

   // A requester is eligible for a grant whenever its pending counter is nonzero.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pendNz[i] = |pendCnt_q[i];
      end
   end

   rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
      .pend_i  (pendNz),
      .ptr_i   (rrPtr_q),
      .en_i    ((state_q == S_IDLE) && !busy),
      .gnt_o   (gntIdx),
      .valid_o (gntValid)
   );

   // A request landing in the issue cycle of its own requester cancels the decrement; otherwise
   // requests count up, and a request against a full counter is reported as a drop.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pendCnt_d[i] = pendCnt_q[i];
         drop_d[i]    = 1'b0;
         if ((state_q == S_ISSUE) && (syncId_q == ID_W'(i))) begin
            if (!req[i]) begin
               pendCnt_d[i] = pendCnt_q[i] - 1'b1;
            end
         end else if (req[i]) begin
            if (pendCnt_q[i] == CNT_MAX) begin
               drop_d[i] = 1'b1;
            end else begin
               pendCnt_d[i] = pendCnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Pending counters and one-cycle drop flags; reset discards any queued events.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pendCnt_q[i] <= '0;
         end
         drop_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pendCnt_q[i] <= pendCnt_d[i];
         end
         drop_q <= drop_d;
      end
   end

   // Transfer sequencer: grant, single pulse, wait for busy to rise and fall (or time out), then idle gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rrPtr_q     <= '0;
         syncId_q    <= '0;
         syncPulse_q <= 1'b0;
         tmoErr_q    <= 1'b0;
         tmoCnt_q    <= '0;
         gapCnt_q    <= '0;
      end else begin
         syncPulse_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (gntValid) begin
                  syncId_q    <= gntIdx;
                  rrPtr_q     <= (gntIdx == ID_W'(NUM_REQ - 1)) ? '0 : gntIdx + ID_W'(1);
                  syncPulse_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmoCnt_q <= '0;
               state_q  <= S_WAIT_HI;
            end
            S_WAIT_HI: begin
               if (busy) begin
                  state_q <= S_WAIT_LO;
               end else if (tmoCnt_q == TMO_W'(TMO - 1)) begin
                  tmoErr_q <= 1'b1;
                  gapCnt_q <= '0;
                  state_q  <= (GAP == 0) ? S_IDLE : S_GAP_WAIT;
               end else begin
                  tmoCnt_q <= tmoCnt_q + TMO_W'(1);
               end
            end
            S_WAIT_LO: begin
               if (!busy) begin
                  gapCnt_q <= '0;
                  state_q  <= (GAP == 0) ? S_IDLE : S_GAP_WAIT;
               end
            end
            S_GAP_WAIT: begin
               if (gapCnt_q == 4'(GAP - 1)) begin
                  state_q <= S_IDLE;
               end else begin
                  gapCnt_q <= gapCnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign sync_pulse = syncPulse_q;
   assign sync_id    = syncId_q;
   assign drop       = drop_q;
   assign tmo_err    = tmoErr_q;
   assign idle       = (state_q == S_IDLE) && !(|pendNz);

endmodule

// File: tb/tb_pulse_sync_sched.sv
// Randomized bench for pulse_sync_sched against a timeline-based reference model.
module tb_pulse_sync_sched;

   localparam int NUM_REQ    = 4;
   localparam int CNT_W      = 3;
   localparam int GAP        = 2;
   localparam int TMO        = 16;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
   localparam int NUM_CYCLES = 5000;
   localparam int DRAIN      = 1000;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req;
   logic                       busy;
   logic                       sync_pulse;
   logic [$clog2(NUM_REQ)-1:0] sync_id;
   logic [NUM_REQ-1:0]         drop;
   logic                       tmo_err;
   logic                       idle;

   always #5 clk = ~clk;

   pulse_sync_sched #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W),
      .GAP     (GAP),
      .TMO     (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .busy       (busy),
      .sync_pulse (sync_pulse),
      .sync_id    (sync_id),
      .drop       (drop),
      .tmo_err    (tmo_err),
      .idle       (idle)
   );

   int checkCount = 0;
   int failCount  = 0;
   int cycleNum   = 0;

   // Reference model: pending event counts plus a timeline of when the scheduler is next free.
   int               pend [NUM_REQ];
   int               ptr;
   int               syncIdE;
   bit               pulseE;
   bit [NUM_REQ-1:0] dropE;
   bit               tmoE;
   int               tmoAt;
   int               readyCycle;
   int               bHiStart;
   int               bHiEnd;
   bit               midResetDone;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycleNum, actual, expected);
      end
   endtask

   function automatic bit allZero();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pend[i] != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic modelReset(input int t);
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
      ptr        = 0;
      syncIdE    = 0;
      pulseE     = 1'b0;
      dropE      = '0;
      tmoE       = 1'b0;
      tmoAt      = -1;
      readyCycle = t;
      bHiStart   = -1;
      bHiEnd     = -1;
   endtask

   task automatic compareOutputs(input int t);
      bit idleE;
      if (tmoAt >= 0 && t >= tmoAt) tmoE = 1'b1;
      idleE = (t >= readyCycle) && allZero();
      checkOutput("sync_pulse", 32'(sync_pulse), 32'(pulseE));
      checkOutput("sync_id",    32'(sync_id),    32'(syncIdE));
      checkOutput("drop",       32'(drop),       32'(dropE));
      checkOutput("tmo_err",    32'(tmo_err),    32'(tmoE));
      checkOutput("idle",       32'(idle),       32'(idleE));
   endtask

   task automatic applyStimulus(input int t);
      bit               rstIn;
      bit               busyIn;
      bit [NUM_REQ-1:0] reqIn;
      int               density;
      bit               pulseNow;
      int               idNow;
      bit               grantNow;
      int               g;
      bit [NUM_REQ-1:0] dropNext;
      int               mode;
      int               d;
      int               p;

      // reset: start-up, a rare random one, and one forced while a transfer is in its busy phase
      rstIn = (t < 3) || ($urandom_range(0, 599) == 0);
      if (!midResetDone && t >= 1200 && bHiStart >= 0 && t > bHiStart && t < bHiEnd && !allZero()) begin
         rstIn        = 1'b1;
         midResetDone = 1'b1;
      end

      if (t < 1000)                       density = 8;
      else if (t < 2000)                  density = 2;
      else if (t < NUM_CYCLES - DRAIN)    density = 20;
      else                                density = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         reqIn[i] = (density != 0) && ($urandom_range(0, density - 1) == 0);
      end

      if (rstIn) begin
         bHiStart = -1;
         bHiEnd   = -1;
      end
      busyIn = (bHiStart >= 0) && (t >= bHiStart) && (t < bHiEnd);
      if (!rstIn && !busyIn && t >= readyCycle && $urandom_range(0, 9) == 0) busyIn = 1'b1;

      rst_n = !rstIn;
      req   = reqIn;
      busy  = busyIn;

      if (rstIn) begin
         modelReset(t + 1);
         return;
      end

      pulseNow = pulseE;
      idNow    = syncIdE;
      grantNow = 1'b0;
      g        = 0;
      if (t >= readyCycle && !busyIn) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (ptr + k) % NUM_REQ;
            if (!grantNow && pend[idx] > 0) begin
               grantNow = 1'b1;
               g        = idx;
            end
         end
      end

      dropNext = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pulseNow && i == idNow) begin
            if (!reqIn[i]) pend[i]--;
         end else if (reqIn[i]) begin
            if (pend[i] == CNT_MAX) dropNext[i] = 1'b1;
            else                    pend[i]++;
         end
      end
      dropE  = dropNext;
      pulseE = grantNow;

      if (grantNow) begin
         syncIdE = g;
         ptr     = (g + 1) % NUM_REQ;
         p       = t + 1;
         mode    = $urandom_range(0, 9);
         if (mode < 2) begin
            bHiStart   = -1;
            bHiEnd     = -1;
            tmoAt      = p + TMO + 1;
            readyCycle = p + TMO + GAP + 1;
         end else begin
            d          = (mode == 2) ? TMO - 1 : $urandom_range(0, 3);
            bHiStart   = p + 1 + d;
            bHiEnd     = bHiStart + $urandom_range(1, 4);
            readyCycle = bHiEnd + GAP + 1;
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      req          = '0;
      busy         = 1'b0;
      midResetDone = 1'b0;
      modelReset(0);
      for (int t = 0; t < NUM_CYCLES; t++) begin
         @(posedge clk);
         #1;
         cycleNum = t;
         compareOutputs(t);
         applyStimulus(t);
      end
      if (!midResetDone) begin
         failCount++;
         $display("[TB] FAIL mid_transfer_reset cycle=%0d got=0 expected=1", cycleNum);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/pulse_sync_sched.md
PULSE_SYNC_SCHED -- requirements
Module: pulse_sync_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of event requesters (2..8).
REQ-002 SHALL have parameter CNT_W, default 3, meaning width of each per-requester pending counter.
REQ-003 SHALL have parameter GAP, default 2, meaning minimum idle cycles between end of one transfer and next issue (0..15).
REQ-004 SHALL have parameter TMO, default 16, meaning cycles allowed for busy to rise after issue.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-007 SHALL have port req, input, NUM_REQ, one-cycle event pulses, one bit per requester.
REQ-008 SHALL have port busy, input, 1, handshake busy from the pulse-synchronizer source side.
REQ-009 SHALL have port sync_pulse, output, 1, one-cycle pulse driven to the synchronizer d_in.
REQ-010 SHALL have port sync_id, output, clog2(NUM_REQ), requester index of the current or last transfer.
REQ-011 SHALL have port drop, output, NUM_REQ, one-cycle flag that the requester's event was lost to saturation.
REQ-012 SHALL have port tmo_err, output, 1, sticky flag that busy never rose within TMO cycles.
REQ-013 SHALL have port idle, output, 1, high when FSM is in IDLE and all counters are zero.

Function
REQ-014 SHALL keep one pending counter per requester, saturating at 2^CNT_W-1.
REQ-015 On req[i]=1 with no issue to i in the same cycle, counter i SHALL increment unless saturated.
REQ-016 On req[i]=1 at saturation, counter i SHALL hold and drop[i] SHALL be 1 the next cycle.
REQ-017 On req[i]=1 in the same cycle as an issue to i, counter i SHALL stay unchanged, with no drop.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_HI, WAIT_LO and GAP_WAIT.
REQ-019 In IDLE with any counter nonzero and busy=0, the FSM SHALL grant round-robin, starting at last grant+1 and wrapping at NUM_REQ-1 to 0; sync_id SHALL be registered; next state ISSUE.
REQ-020 In ISSUE, sync_pulse SHALL be 1 for exactly one cycle, the granted counter SHALL decrement, and next state SHALL be WAIT_HI.
REQ-021 WAIT_HI SHALL go to WAIT_LO when busy=1.
REQ-022 If busy stays 0 for TMO cycles in WAIT_HI, the FSM SHALL set tmo_err and go to GAP_WAIT; the event is considered consumed.
REQ-023 WAIT_LO SHALL go to GAP_WAIT when busy=0.
REQ-024 GAP_WAIT SHALL count GAP cycles and then go to IDLE; GAP=0 SHALL go directly to IDLE.
REQ-025 Issue-to-issue latency SHALL be at least 1 cycle (grant) + 1 cycle (pulse) + busy duration + GAP + 1 cycle.
REQ-026 sync_id SHALL hold its value outside ISSUE.
REQ-027 busy=1 while in IDLE SHALL block granting; no pulse SHALL be issued until busy=0.
REQ-028 Only one sync_pulse SHALL ever be outstanding.

Reset
REQ-029 rst_n=0 at a clock edge SHALL set state to IDLE, clear all counters, set sync_pulse=0, sync_id=0, drop=0 and tmo_err=0, and set the round-robin pointer so requester 0 is granted first.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer; pending events SHALL be lost and no pulse SHALL follow reset.
REQ-031 req SHALL be ignored while rst_n=0.

Structure
REQ-032 Package pulse_sync_pkg SHALL hold the FSM state enum and the default constants NUM_REQ, CNT_W, GAP and TMO.
REQ-033 The round-robin grant logic SHALL be a sub-module rr_arb with inputs pending-nonzero vector, pointer and enable, and outputs grant index and valid.
REQ-034 The counters, FSM, timeout counter and gap counter SHALL live in pulse_sync_sched.

Verification
REQ-035 Single event: req=4'b0010 for 1 cycle with busy responding 2 cycles after pulse for 3 cycles -> one sync_pulse, sync_id=1, idle=1 after GAP.
REQ-036 Round robin: req=4'b1111 once -> sync_id sequence 0,1,2,3, with each pulse separated by at least busy+GAP cycles.
REQ-037 Saturation: 8 back-to-back req[2] pulses with busy held 1 -> counter reaches 7, drop[2]=1 on the 8th, and 7 pulses eventually issued.
REQ-038 Simultaneous: req[0]=1 in the ISSUE cycle of id 0 with counter=1 -> counter stays 1 and a second pulse for id 0 follows.
REQ-039 Timeout: busy tied 0 -> tmo_err=1 after TMO cycles, FSM returns to IDLE, and the next pending event still issues.
REQ-040 Reset mid-WAIT_LO with counters nonzero -> all outputs are at reset values and no sync_pulse occurs without new req.
